// File: rtl/rotr_pkg.sv
// Shared state encoding for the right-rotate sequencer.
package rotr_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/right_rotate_reg.sv
// Word register that loads in parallel or rotates right by one bit per enabled clock.
module right_rotate_reg #(
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  logic [DW-1:0] rot;

  // Bit i takes its upper neighbour; the top bit wraps around from bit 0.
  for (genvar i = 0; i < DW; i++) begin : g_rot
    localparam int unsigned Src = (i + 1) % DW;
    assign rot[i] = q[Src];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (en) begin
      q <= rot;
    end
  end

endmodule

// File: rtl/rotr_seq_unit.sv
// Multi-cycle right-rotate engine: accepts a word and amount, rotates one bit per clock,
// then holds the result until the consumer takes it.
module rotr_seq_unit
  import rotr_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned SW = 2
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data,
  input  logic [SW-1:0] amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic          busy
);

  localparam logic [SW-1:0] CntOne = SW'(1);

  state_e        state;
  logic [SW-1:0] cnt;
  logic          accept;
  logic          rot_en;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // flush blocks both the load and the rotation so q freezes where it is.
  assign accept = (state == IDLE) & in_valid & ~flush;
  assign rot_en = (state == ROT) & ~flush;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= amt;
            state <= (amt != '0) ? ROT : DONE;
          end
        end
        ROT: begin
          cnt <= cnt - CntOne;
          if (cnt == CntOne) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  right_rotate_reg #(
    .DW(DW)
  ) u_rot_reg (
    .clk  (clk),
    .clear(async_rst),
    .load (accept),
    .en   (rot_en),
    .data (data),
    .q    (q)
  );

endmodule

// File: tb/tb_rotr_seq_unit.sv
// Bench for rotr_seq_unit: directed cases plus randomized traffic against a timestamp model.
module tb_rotr_seq_unit;

  localparam int unsigned DW = 4;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          async_rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data;
  logic [SW-1:0] amt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  rotr_seq_unit #(
    .DW(DW),
    .SW(SW)
  ) dut (
    .clk      (clk),
    .async_rst(async_rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .amt      (amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rotr_f(logic [DW-1:0] v, int k);
    int s;
    s = k % DW;
    if (s == 0) return v;
    return (v >> s) | (v << (DW - s));
  endfunction

  function automatic logic [DW-1:0] rotl_f(logic [DW-1:0] v, int k);
    int s;
    s = k % DW;
    if (s == 0) return v;
    return (v << s) | (v >> (DW - s));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a command is a (word, amount, accept time); the visible word is the input
  // rotated by however many cycles have elapsed, capped at the amount.
  int            cyc = 0;
  bit            m_active = 1'b0;
  logic [DW-1:0] m_d;
  int            m_a;
  int            m_t0;
  logic [DW-1:0] m_held = '0;

  function automatic logic [DW-1:0] exp_q();
    int e;
    if (!m_active) return m_held;
    e = cyc - m_t0;
    if (e > m_a) e = m_a;
    return rotr_f(m_d, e);
  endfunction

  function automatic bit exp_done();
    return m_active && ((cyc - m_t0) >= m_a);
  endfunction

  always @(posedge clk or posedge async_rst) begin
    logic [DW-1:0] pre_q;
    bit            pre_done;
    if (async_rst) begin
      m_active = 1'b0;
      m_held   = '0;
    end else begin
      pre_q    = exp_q();
      pre_done = exp_done();
      cyc++;
      if (flush) begin
        m_held   = pre_q;
        m_active = 1'b0;
      end else if (!m_active) begin
        if (in_valid) begin
          m_active = 1'b1;
          m_d      = data;
          m_a      = int'(amt);
          m_t0     = cyc;
        end
      end else if (pre_done && out_ready) begin
        m_held   = pre_q;
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !async_rst) begin
      chk("model_in_ready", 32'(in_ready), 32'(!m_active));
      chk("model_out_valid", 32'(out_valid), 32'(exp_done()));
      chk("model_busy", 32'(busy), 32'(m_active));
      chk("model_q", 32'(q), 32'(exp_q()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] a);
    in_valid = 1'b1;
    data     = d;
    amt      = a;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int            n;
    logic [DW-1:0] w;
    int            k;

    async_rst = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    data      = '0;
    amt       = '0;
    out_ready = 1'b1;
    repeat (2) step();
    async_rst = 1'b0;
    chk_en    = 1'b1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // amt=1
    send(4'b1011, 2'd1);
    chk("a1_no_valid_yet", 32'(out_valid), 32'h0);
    step();
    chk("a1_valid", 32'(out_valid), 32'h1);
    chk("a1_q", 32'(q), 32'(4'b1101));
    step();
    chk("a1_idle", 32'(in_ready), 32'h1);

    // amt=3, in_valid pulse during rotation must be ignored
    send(4'b1011, 2'd3);
    step();
    chk("a3_e1", 32'(out_valid), 32'h0);
    in_valid = 1'b1;
    data     = 4'b0000;
    amt      = 2'd0;
    step();
    chk("a3_e2", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    step();
    chk("a3_valid", 32'(out_valid), 32'h1);
    chk("a3_q", 32'(q), 32'(4'b0111));
    step();
    chk("a3_idle", 32'(in_ready), 32'h1);

    // amt=0 with a 5-cycle consumer stall
    out_ready = 1'b0;
    send(4'b0110, 2'd0);
    chk("a0_valid", 32'(out_valid), 32'h1);
    chk("a0_q", 32'(q), 32'(4'b0110));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_q", 32'(q), 32'(4'b0110));
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", 32'(in_ready), 32'h1);

    // flush after one rotation
    send(4'b1000, 2'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_q", 32'(q), 32'(4'b0100));
    chk("flush_idle", 32'(in_ready), 32'h1);
    chk("flush_no_valid", 32'(out_valid), 32'h0);
    step();
    chk("flush_no_valid2", 32'(out_valid), 32'h0);

    // flush together with in_valid in IDLE: not accepted
    flush = 1'b1;
    send(4'b1111, 2'd2);
    flush = 1'b0;
    chk("flush_blocks_accept", 32'(in_ready), 32'h1);
    chk("flush_blocks_q", 32'(q), 32'(4'b0100));

    send(4'b0001, 2'd2);
    step();
    step();
    chk("post_flush_valid", 32'(out_valid), 32'h1);
    chk("post_flush_q", 32'(q), 32'(4'b0100));
    step();

    // async reset in the middle of a rotation, between clock edges
    send(4'b1110, 2'd3);
    step();
    #2;
    async_rst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    step();
    async_rst = 1'b0;
    step();

    // round trip: undo a left rotation, with random consumer stalls
    for (int v = 0; v < 200; v++) begin
      w         = DW'($urandom);
      k         = int'($urandom_range(0, 3));
      out_ready = 1'($urandom);
      send(rotl_f(w, k), SW'(k));
      n = 0;
      while (!out_valid && n < 20) begin
        out_ready = 1'($urandom);
        step();
        n++;
      end
      chk("rt_timeout", 32'(n < 20), 32'h1);
      chk("rt_q", 32'(q), 32'(w));
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'b0;
        step();
      end
      out_ready = 1'b1;
      step();
    end

    // unconstrained traffic including flushes; the compare process does the checking
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      data      = DW'($urandom);
      amt       = SW'($urandom);
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotr_seq_unit.md
Name: rotr_seq_unit

Overview:
- Multi-cycle right-rotate engine. It is the inverse companion of the team's left-rotate register: it undoes a left rotation of a word by a commanded amount.
- Accepts a word and a rotate amount over a valid/ready input handshake, rotates right one bit per clock, then presents the result over a valid/ready output handshake.
- Sits between a producer of left-rotated words and the downstream consumer that needs the original alignment.

Parameters:
- DW, 4: data width in bits; must be at least 2.
- SW, 2: width of the rotate-amount field. Amounts from 0 to 2^SW-1 are legal; an amount of DW or more wraps naturally, since DW steps is the identity.

Ports:
- clk  in  1  rising-edge clock
- async_rst  in  1  asynchronous reset, active-high. One clock. Reset is asynchronous and active-high.
- flush  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  input word and amount are valid
- in_ready  out  1  block can accept a command; high only in IDLE
- data  in  DW  word to rotate
- amt  in  SW  number of single-bit right rotations
- out_valid  out  1  q holds the final result
- out_ready  in  1  consumer takes the result
- q  out  DW  working/result register
- busy  out  1  high in ROT or DONE

Behaviour:
- Reset (async, while async_rst=1):
  - state=IDLE, q=0, cnt=0.
  - Outputs: out_valid=0, busy=0, in_ready=1.
- States (localparams, 2-bit encoding): IDLE=0, ROT=1, DONE=2.
- Derived outputs (combinational from state):
  - in_ready = (state==IDLE)
  - out_valid = (state==DONE)
  - busy = (state!=IDLE)
- IDLE:
  - On an edge with in_valid=1: q<=data and cnt<=amt.
  - If amt!=0 go to ROT, else go to DONE.
  - With in_valid=0: q and cnt hold.
- ROT:
  - Each edge: q<={q[0],q[DW-1:1]} and cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
  - in_valid is ignored; data and amt are not sampled.
- DONE:
  - q holds stable.
  - On an edge with out_ready=1, go to IDLE; q keeps its value.
  - With out_ready=0, stay in DONE indefinitely.
- Latency:
  - The result is valid exactly amt cycles after the accept edge.
  - amt=0 gives out_valid=1 in the cycle right after the accept edge, with q=data.
- Throughput: one command per (amt+2) cycles at best. There is no accept in the same cycle as a result handoff, because in_ready is low in DONE.
- flush:
  - Synchronous, and has priority over every transition.
  - Next state=IDLE, cnt<=0, q holds its current value. An in-flight command is discarded, and out_valid drops on the next cycle.
  - An input with in_valid=1 in the same cycle as flush is not accepted, even in IDLE.
- async_rst mid-operation: immediate return to reset values, independent of clk.
- Width rules:
  - cnt is SW bits and only decrements in ROT, where cnt>=1, so it never underflows.
  - No data bits are lost; rotation is a pure permutation.

Decomposition:
- Package rotr_pkg:
  - state localparams IDLE, ROT, DONE
  - the state width constant ST_W=2
- Sub-module right_rotate_reg (parameter DW):
  - per-bit registered datapath with load, en, data, q
  - clear = async_rst
  - priority load > en > hold
  - bit i takes q[i+1]; bit DW-1 takes q[0]
- rotr_seq_unit instantiates one right_rotate_reg and drives load=accept, en=(state==ROT)&~flush. Control FSM and counter stay in the top.

Test Plan (DW=4, SW=2):
- Reset: assert async_rst between edges -> q=0000, in_ready=1, out_valid=0 before the next clk edge.
- data=1011, amt=1, out_ready=1 -> out_valid high 1 cycle after accept, q=1101, then IDLE.
- data=1011, amt=3 -> out_valid exactly 3 cycles after accept, q=0111 (equals rotl1 of 1011). in_valid pulses during ROT are ignored.
- data=0110, amt=0 -> out_valid the cycle after accept, q=0110. Hold out_ready=0 for 5 cycles -> q stable, in_ready=0 throughout.
- data=1000, amt=3, flush after 1 rotation -> q=0100 held, state IDLE, out_valid never asserted. The next command data=0001, amt=2 gives q=0100.
- Round trip: left-rotate a random word by k∈{0..3} in the bench, feed it with amt=k -> q equals the original word. Run 200 random vectors with random out_ready stalls.
